// File: rtl/cp0_interrupt_unit.sv
// Coprocessor-0 interrupt source: Status/Cause/EPC, irq synchronisation and
// pending capture, and the RUN/HANDLER/RETURN sequencing that drives inta and eret_sel.
module cp0_interrupt_unit #(
  parameter int          NUM_IRQ      = 6,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0080
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [31:0]        pc_id,
  input  logic               id_valid,
  input  logic               eret_id,
  input  logic               cp0_we,
  input  logic [4:0]         cp0_waddr,
  input  logic [31:0]        cp0_wdata,
  input  logic [4:0]         cp0_raddr,
  output logic [31:0]        cp0_rdata,
  output logic               inta,
  output logic [31:0]        int_vector,
  output logic               eret_sel,
  output logic [31:0]        epc_out
);
  typedef enum logic [1:0] {S_RUN, S_HANDLER, S_RETURN} state_t;

  localparam logic [4:0] A_STATUS = 5'd12;
  localparam logic [4:0] A_CAUSE  = 5'd13;
  localparam logic [4:0] A_EPC    = 5'd14;

  state_t             state;
  logic               ie, exl;
  logic [7:0]         im;
  logic [NUM_IRQ-1:0] ip, rise, ip_clr;
  logic [31:0]        epc;
  logic [7:0]         ip8;
  logic               wr_status, wr_cause, wr_epc, take;

  // Per-line 2-flop synchroniser plus one history flop for rising-edge detect
  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_sync
    logic [2:0] sh;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sh <= '0;
      else        sh <= {sh[1:0], irq[gi]};
    end
    assign rise[gi] = sh[1] & ~sh[2];
  end

  assign wr_status = cp0_we && (cp0_waddr == A_STATUS);
  assign wr_cause  = cp0_we && (cp0_waddr == A_CAUSE);
  assign wr_epc    = cp0_we && (cp0_waddr == A_EPC);
  assign ip_clr    = wr_cause ? cp0_wdata[8 +: NUM_IRQ] : '0;

  assign take = (state == S_RUN) && ie && !exl && |(ip & im[NUM_IRQ-1:0])
              && id_valid && !eret_id;

  assign inta       = take;
  assign int_vector = HANDLER_ADDR;
  assign eret_sel   = eret_id;
  assign epc_out    = epc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RUN;
      ie    <= 1'b0;
      exl   <= 1'b0;
      im    <= '0;
      ip    <= '0;
      epc   <= '0;
    end else begin
      // W1C first, then new edges so a same-edge set wins
      ip <= (ip & ~ip_clr) | rise;
      if (wr_status) begin
        ie  <= cp0_wdata[0];
        im  <= cp0_wdata[15:8];
      end
      if (take)        epc <= pc_id;
      else if (wr_epc) epc <= cp0_wdata;
      // Hardware EXL updates override a same-edge mtc0 to Status
      case (state)
        S_RUN: begin
          if (take) begin
            state <= S_HANDLER;
            exl   <= 1'b1;
          end else if (eret_id) exl <= 1'b0;
          else if (wr_status)   exl <= cp0_wdata[1];
        end
        S_HANDLER: begin
          if (eret_id)   state <= S_RETURN;
          if (wr_status) exl   <= cp0_wdata[1];
        end
        S_RETURN: begin
          exl   <= 1'b0;
          state <= S_RUN;
        end
        default: state <= S_RUN;
      endcase
    end
  end

  always_comb begin
    ip8 = '0;
    ip8[NUM_IRQ-1:0] = ip;
  end

  // ExcCode is always 0: interrupts are the only exception entered here
  always_comb begin
    case (cp0_raddr)
      A_STATUS: cp0_rdata = {16'h0, im, 6'h0, exl, ie};
      A_CAUSE:  cp0_rdata = {16'h0, ip8, 8'h0};
      A_EPC:    cp0_rdata = epc;
      default:  cp0_rdata = 32'h0;
    endcase
  end
endmodule

// File: tb/tb_cp0_interrupt_unit.sv
// Bench for cp0_interrupt_unit: directed scenarios plus a randomized run,
// all compared against a behavioural CP0 model kept in the bench.
module tb_cp0_interrupt_unit;
  localparam int N = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  irq = '0;
  logic [31:0]   pc_id = '0;
  logic          id_valid = 1'b0;
  logic          eret_id = 1'b0;
  logic          cp0_we = 1'b0;
  logic [4:0]    cp0_waddr = '0;
  logic [31:0]   cp0_wdata = '0;
  logic [4:0]    cp0_raddr = '0;
  logic [31:0]   cp0_rdata, int_vector, epc_out;
  logic          inta, eret_sel;

  int checks = 0;
  int errors = 0;

  cp0_interrupt_unit #(.NUM_IRQ(N), .HANDLER_ADDR(32'h0000_0080)) dut (
    .clk(clk), .rst_n(rst_n), .irq(irq), .pc_id(pc_id), .id_valid(id_valid),
    .eret_id(eret_id), .cp0_we(cp0_we), .cp0_waddr(cp0_waddr),
    .cp0_wdata(cp0_wdata), .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata),
    .inta(inta), .int_vector(int_vector), .eret_sel(eret_sel), .epc_out(epc_out)
  );

  always #5 clk = ~clk;

  // Reference model: architectural registers, a mode (0 run, 1 handler,
  // 2 return) and the irq levels seen at the last three clock edges.
  logic         m_ie, m_exl;
  logic [7:0]   m_im;
  logic [N-1:0] m_ip;
  logic [31:0]  m_epc;
  int           m_mode;
  logic [N-1:0] smp [3];

  task automatic model_reset();
    m_ie = 0; m_exl = 0; m_im = '0; m_ip = '0; m_epc = '0; m_mode = 0;
    for (int k = 0; k < 3; k++) smp[k] = '0;
  endtask

  function automatic logic m_take();
    return (m_mode == 0) && m_ie && !m_exl && (|(m_ip & m_im[N-1:0]))
           && id_valid && !eret_id;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [4:0] a);
    logic [7:0] p;
    p = '0;
    p[N-1:0] = m_ip;
    case (a)
      5'd12:   return {16'h0, m_im, 6'h0, m_exl, m_ie};
      5'd13:   return {16'h0, p, 8'h0};
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  // An irq rise becomes pending on the third clock edge after it is sampled.
  task automatic model_update();
    logic         t;
    logic [N-1:0] rise, clr;
    t    = m_take();
    rise = smp[1] & ~smp[2];
    smp[2] = smp[1]; smp[1] = smp[0]; smp[0] = irq;
    clr  = '0;
    if (cp0_we) begin
      if (cp0_waddr == 5'd12) begin
        m_ie = cp0_wdata[0]; m_exl = cp0_wdata[1]; m_im = cp0_wdata[15:8];
      end
      if (cp0_waddr == 5'd13) clr = cp0_wdata[8 +: N];
      if (cp0_waddr == 5'd14) m_epc = cp0_wdata;
    end
    m_ip = (m_ip & ~clr) | rise;
    if (m_mode == 0) begin
      if (t) begin m_epc = pc_id; m_exl = 1; m_mode = 1; end
      else if (eret_id) m_exl = 0;
    end else if (m_mode == 1) begin
      if (eret_id) m_mode = 2;
    end else begin
      m_exl = 0; m_mode = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    cp0_we = 1; cp0_waddr = a; cp0_wdata = d;
    tick();
    cp0_we = 0;
  endtask

  task automatic apply_reset();
    irq = '0; cp0_we = 0; eret_id = 0; id_valid = 1;
    @(negedge clk);
    rst_n = 0;
    model_reset();
    #2 rst_n = 1;
    tick();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (inta !== 1'b0) begin errors++; $display("FAIL reset_inta got=%b exp=0", inta); end
    checks++; if (epc_out !== 32'h0) begin errors++; $display("FAIL reset_epc got=%h exp=0", epc_out); end
    checks++; if (int_vector !== 32'h80) begin errors++; $display("FAIL int_vector got=%h exp=00000080", int_vector); end
    for (int a = 12; a <= 14; a++) begin
      cp0_raddr = 5'(a); #1;
      checks++; if (cp0_rdata !== 32'h0) begin errors++; $display("FAIL reset_reg%0d got=%h exp=0", a, cp0_rdata); end
    end
    tick();
  endtask

  task automatic test_basic_entry();
    int first, cnt;
    apply_reset();
    pc_id = 32'h100;
    mtc0(5'd12, 32'h401);
    irq[2] = 1;
    first = -1; cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (inta === 1'b1) begin cnt++; if (first < 0) first = i; end
      checks++; if (inta !== m_take()) begin errors++; $display("FAIL entry_inta c%0d got=%b exp=%b", i, inta, m_take()); end
      tick();
    end
    checks++; if (first != 3) begin errors++; $display("FAIL entry_latency got=%0d exp=3", first); end
    checks++; if (cnt != 1) begin errors++; $display("FAIL entry_width got=%0d exp=1", cnt); end
    @(negedge clk);
    cp0_raddr = 5'd12; #1;
    checks++; if (cp0_rdata !== 32'h403) begin errors++; $display("FAIL entry_status got=%h exp=00000403", cp0_rdata); end
    cp0_raddr = 5'd13; #1;
    checks++; if (cp0_rdata !== 32'h400) begin errors++; $display("FAIL entry_cause got=%h exp=00000400", cp0_rdata); end
    checks++; if (epc_out !== 32'h100) begin errors++; $display("FAIL entry_epc got=%h exp=00000100", epc_out); end
    tick();
  endtask

  // Continues from the handler state left by test_basic_entry.
  task automatic test_nesting_return();
    irq[2] = 0;
    mtc0(5'd13, 32'h400);
    repeat (3) tick();
    irq[2] = 1;
    pc_id = 32'h104;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (inta !== 1'b0) begin errors++; $display("FAIL nest_inta c%0d got=%b exp=0", i, inta); end
      tick();
    end
    @(negedge clk);
    cp0_raddr = 5'd13; #1;
    checks++; if (cp0_rdata !== 32'h400) begin errors++; $display("FAIL nest_pending got=%h exp=00000400", cp0_rdata); end
    eret_id = 1; #1;
    checks++; if (eret_sel !== 1'b1) begin errors++; $display("FAIL eret_sel got=%b exp=1", eret_sel); end
    checks++; if (epc_out !== 32'h100) begin errors++; $display("FAIL eret_epc got=%h exp=00000100", epc_out); end
    checks++; if (inta !== 1'b0) begin errors++; $display("FAIL eret_inta got=%b exp=0", inta); end
    tick();
    eret_id = 0;
    @(negedge clk);
    cp0_raddr = 5'd12; #1;
    checks++; if (cp0_rdata !== 32'h403) begin errors++; $display("FAIL return_status got=%h exp=00000403", cp0_rdata); end
    checks++; if (inta !== 1'b0) begin errors++; $display("FAIL return_inta got=%b exp=0", inta); end
    tick();
    @(negedge clk);
    checks++; if (cp0_rdata !== 32'h401) begin errors++; $display("FAIL after_return_status got=%h exp=00000401", cp0_rdata); end
    checks++; if (inta !== 1'b1) begin errors++; $display("FAIL second_take got=%b exp=1", inta); end
    tick();
    @(negedge clk);
    checks++; if (epc_out !== 32'h104) begin errors++; $display("FAIL second_epc got=%h exp=00000104", epc_out); end
    tick();
  endtask

  task automatic test_mask_bubble();
    apply_reset();
    mtc0(5'd12, 32'h001);
    irq[0] = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if (inta !== 1'b0) begin errors++; $display("FAIL masked_inta c%0d got=%b exp=0", i, inta); end
      tick();
    end
    @(negedge clk);
    cp0_raddr = 5'd13; #1;
    checks++; if (cp0_rdata !== 32'h100) begin errors++; $display("FAIL masked_pending got=%h exp=00000100", cp0_rdata); end
    id_valid = 0;
    mtc0(5'd12, 32'h101);
    @(negedge clk);
    checks++; if (inta !== 1'b0) begin errors++; $display("FAIL bubble_inta got=%b exp=0", inta); end
    tick();
    id_valid = 1;
    @(negedge clk);
    checks++; if (inta !== 1'b1) begin errors++; $display("FAIL unbubble_inta got=%b exp=1", inta); end
    tick();
  endtask

  task automatic test_collisions();
    bit seen;
    apply_reset();
    mtc0(5'd12, 32'h400);
    irq[2] = 1; repeat (4) tick();
    irq[2] = 0; repeat (4) tick();
    irq[2] = 1; tick(); tick();
    mtc0(5'd13, 32'h400);
    @(negedge clk);
    cp0_raddr = 5'd13; #1;
    checks++; if (cp0_rdata !== 32'h400) begin errors++; $display("FAIL w1c_vs_edge got=%h exp=00000400", cp0_rdata); end
    tick();
    mtc0(5'd13, 32'h400);
    @(negedge clk);
    checks++; if (cp0_rdata !== 32'h0) begin errors++; $display("FAIL w1c_clear got=%h exp=0", cp0_rdata); end
    tick();
    irq[2] = 0;
    mtc0(5'd12, 32'h401);
    repeat (4) tick();
    irq[2] = 1; pc_id = 32'h300;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (inta === 1'b1) begin
        seen = 1;
        cp0_we = 1; cp0_waddr = 5'd14; cp0_wdata = 32'h200;
      end
      tick();
      cp0_we = 0;
    end
    checks++; if (!seen) begin errors++; $display("FAIL take_timeout got=0 exp=1"); end
    @(negedge clk);
    cp0_raddr = 5'd12; #1;
    checks++; if (epc_out !== 32'h300) begin errors++; $display("FAIL take_vs_mtc0_epc got=%h exp=00000300", epc_out); end
    checks++; if (cp0_rdata !== 32'h403) begin errors++; $display("FAIL take_status got=%h exp=00000403", cp0_rdata); end
    tick();
    mtc0(5'd14, 32'h200);
    @(negedge clk);
    checks++; if (epc_out !== 32'h200) begin errors++; $display("FAIL handler_mtc0_epc got=%h exp=00000200", epc_out); end
    tick();
  endtask

  task automatic test_reset_mid();
    bit seen;
    apply_reset();
    pc_id = 32'h40;
    mtc0(5'd12, 32'h401);
    irq[2] = 1;
    repeat (6) tick();
    @(negedge clk);
    checks++; if (epc_out !== 32'h40) begin errors++; $display("FAIL mid_pre_epc got=%h exp=00000040", epc_out); end
    irq[2] = 0;
    #2 rst_n = 0;
    model_reset();
    #1;
    checks++; if (epc_out !== 32'h0) begin errors++; $display("FAIL mid_reset_epc got=%h exp=0", epc_out); end
    checks++; if (inta !== 1'b0) begin errors++; $display("FAIL mid_reset_inta got=%b exp=0", inta); end
    cp0_raddr = 5'd12; #0.5;
    checks++; if (cp0_rdata !== 32'h0) begin errors++; $display("FAIL mid_reset_status got=%h exp=0", cp0_rdata); end
    #0.5 rst_n = 1;
    tick();
    mtc0(5'd12, 32'h401);
    irq[2] = 1;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (inta === 1'b1) seen = 1;
      tick();
    end
    checks++; if (!seen) begin errors++; $display("FAIL mid_reset_run got=0 exp=1"); end
  endtask

  task automatic test_random();
    logic [4:0] addrs [4];
    addrs[0] = 5'd12; addrs[1] = 5'd13; addrs[2] = 5'd14; addrs[3] = 5'd7;
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 9) == 0) irq[b] = ~irq[b];
      id_valid  = ($urandom_range(0, 3) != 0);
      eret_id   = ($urandom_range(0, 11) == 0);
      pc_id     = {$urandom_range(0, 255), 2'b00};
      cp0_we    = ($urandom_range(0, 6) == 0);
      cp0_waddr = addrs[$urandom_range(0, 3)];
      cp0_wdata = $urandom;
      if (cp0_waddr == 5'd12 && $urandom_range(0, 1) == 1) cp0_wdata[1:0] = 2'b01;
      cp0_raddr = addrs[$urandom_range(0, 3)];
      @(negedge clk);
      checks++; if (inta !== m_take()) begin errors++; $display("FAIL rnd_inta c%0d got=%b exp=%b", i, inta, m_take()); end
      checks++; if (eret_sel !== eret_id) begin errors++; $display("FAIL rnd_eret_sel c%0d got=%b exp=%b", i, eret_sel, eret_id); end
      checks++; if (epc_out !== m_epc) begin errors++; $display("FAIL rnd_epc c%0d got=%h exp=%h", i, epc_out, m_epc); end
      checks++; if (cp0_rdata !== m_rdata(cp0_raddr)) begin errors++; $display("FAIL rnd_rdata c%0d a=%0d got=%h exp=%h", i, cp0_raddr, cp0_rdata, m_rdata(cp0_raddr)); end
      tick();
    end
    cp0_we = 0; eret_id = 0;
  endtask

  initial begin
    model_reset();
    #12 rst_n = 1;
    tick();
    test_reset();
    test_basic_entry();
    test_nesting_return();
    test_mask_bubble();
    test_collisions();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
